// File: rtl/riscv_pkg.sv
// Shared types for the multi-cycle RISC-V controller: opcodes, ALU
// operations, FSM states, the datapath control bundle and the named
// encodings for PC/operand selects and trap causes.
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_I_TYPE = 7'b0010011,
    OP_R_TYPE = 7'b0110011
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } mc_state_t;

  localparam logic [1:0] PC_PLUS4   = 2'b00;
  localparam logic [1:0] PC_IMM     = 2'b01;
  localparam logic [1:0] PC_RS1_IMM = 2'b10;

  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;

  localparam logic [1:0] OPB_RS2  = 2'b00;
  localparam logic [1:0] OPB_IMM  = 2'b01;
  localparam logic [1:0] OPB_FOUR = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] next_pc_sel;
    logic [1:0] op_a_sel;
    logic [1:0] op_b_sel;
    alu_op_t    alu_op;
    logic [2:0] mem_size;
  } ctrl_signals_t;

  // alt is instr[30]; callers decide whether it is honoured.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// Instruction/data memory handshake bundle.
//   imem_req/imem_ready : fetch request and fetch-data-valid
//   dmem_req/dmem_we/dmem_ready : data access request, store flag, completion
// master = controller, slave = memory side.
interface riscv_mc_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ready, dmem_ready);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/riscv_mc_decode.sv
// Combinational instruction decoder.
//   instr     : instruction register contents
//   dec       : static datapath controls for this instruction (enables are
//               raw; the controller gates them by state)
//   legal     : opcode known and funct7 valid for funct3
//   is_branch : instruction is a conditional branch
module riscv_mc_decode
  import riscv_pkg::*;
(
  input  logic [31:0]   instr,
  output ctrl_signals_t dec,
  output logic          legal,
  output logic          is_branch
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_bits;

  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec       = '0;
    dec.alu_op = ALU_ADD;
    legal     = 1'b1;
    is_branch = 1'b0;
    case (instr[6:0])
      OP_R_TYPE: begin
        dec.reg_write = 1'b1;
        dec.op_b_sel  = OPB_RS2;
        dec.alu_op    = alu_from_funct3(f3, instr[30]);
        if (!(f7 == 7'b0000000 ||
              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
          legal = 1'b0;
      end
      OP_I_TYPE: begin
        dec.reg_write = 1'b1;
        dec.op_b_sel  = OPB_IMM;
        // Upper immediate bits are only funct7 for shifts.
        dec.alu_op    = alu_from_funct3(f3, (f3 == 3'b101) && instr[30]);
        if (f3 == 3'b001 && f7 != 7'b0000000)
          legal = 1'b0;
        if (f3 == 3'b101 && !(f7 == 7'b0000000 || f7 == 7'b0100000))
          legal = 1'b0;
      end
      OP_LOAD: begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.op_b_sel  = OPB_IMM;
        dec.mem_size  = f3;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.op_b_sel  = OPB_IMM;
        dec.mem_size  = f3;
      end
      OP_BRANCH: begin
        is_branch       = 1'b1;
        dec.op_b_sel    = OPB_IMM;
        dec.next_pc_sel = PC_IMM;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.op_a_sel  = OPA_ZERO;
        dec.op_b_sel  = OPB_IMM;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.op_a_sel  = OPA_PC;
        dec.op_b_sel  = OPB_IMM;
      end
      OP_JAL: begin
        dec.reg_write   = 1'b1;
        dec.op_a_sel    = OPA_PC;
        dec.op_b_sel    = OPB_FOUR;
        dec.next_pc_sel = PC_IMM;
      end
      OP_JALR: begin
        dec.reg_write   = 1'b1;
        dec.op_a_sel    = OPA_PC;
        dec.op_b_sel    = OPB_FOUR;
        dec.next_pc_sel = PC_RS1_IMM;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RISC-V control FSM with memory-wait timeout.
//   clk, rst      : clock, asynchronous active-high reset
//   instr         : instruction register contents (valid from DECODE)
//   branch_taken  : comparator result for the current branch
//   mem           : imem/dmem request/ready handshakes
//   ir_load       : latch instruction register
//   pc_write      : update PC from ctrl.next_pc_sel
//   ctrl          : datapath controls (all zero in IDLE/FETCH/TRAP)
//   retire        : one-cycle pulse per completed instruction
//   halted        : high in TRAP
//   trap_cause    : 00 none, 01 illegal, 10 bus timeout
module riscv_mc_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            instr,
  input  logic                   branch_taken,
  riscv_mc_ctrl_if.master        mem,
  output logic                   ir_load,
  output logic                   pc_write,
  output ctrl_signals_t          ctrl,
  output logic                   retire,
  output logic                   halted,
  output logic [1:0]             trap_cause
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  mc_state_t     state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    cause_next;
  logic          waiting;
  logic          timeout;
  ctrl_signals_t dec, ctrl_dp;
  logic          legal, is_branch;

  riscv_mc_decode u_decode (
    .instr     (instr),
    .dec       (dec),
    .legal     (legal),
    .is_branch (is_branch)
  );

  // The counter holds completed wait cycles, so the cycle that would make
  // it reach TIMEOUT_CYCLES traps unless ready is seen in that same cycle.
  assign timeout = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      trap_cause <= TRAP_NONE;
    end else begin
      state      <= state_next;
      trap_cause <= cause_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_comb begin
    ctrl_dp           = dec;
    ctrl_dp.reg_write = 1'b0;
    ctrl_dp.mem_write = 1'b0;
    ctrl_dp.mem_read  = 1'b0;
    if (is_branch)
      ctrl_dp.next_pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
  end

  always_comb begin
    state_next   = state;
    cause_next   = trap_cause;
    waiting      = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    retire       = 1'b0;
    halted       = 1'b0;
    ctrl         = '0;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end else begin
          waiting = 1'b1;
          if (timeout) begin
            state_next = S_TRAP;
            cause_next = TRAP_TIMEOUT;
          end
        end
      end
      S_DECODE: begin
        ctrl = ctrl_dp;
        if (!legal) begin
          state_next = S_TRAP;
          cause_next = TRAP_ILLEGAL;
        end else begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        ctrl = ctrl_dp;
        if (dec.mem_read || dec.mem_write) begin
          state_next = S_MEM;
        end else if (is_branch) begin
          pc_write   = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WRITEBACK;
        end
      end
      S_MEM: begin
        ctrl           = ctrl_dp;
        ctrl.mem_read  = dec.mem_read;
        ctrl.mem_write = dec.mem_write;
        mem.dmem_req   = 1'b1;
        mem.dmem_we    = dec.mem_write;
        if (mem.dmem_ready) begin
          if (dec.mem_write) begin
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WRITEBACK;
          end
        end else begin
          waiting = 1'b1;
          if (timeout) begin
            state_next = S_TRAP;
            cause_next = TRAP_TIMEOUT;
          end
        end
      end
      S_WRITEBACK: begin
        ctrl           = ctrl_dp;
        ctrl.reg_write = 1'b1;
        pc_write       = 1'b1;
        retire         = 1'b1;
        state_next     = S_FETCH;
      end
      S_TRAP:  halted = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
module tb_riscv_mc_ctrl;
  import riscv_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          branch_taken;
  logic          ir_load, pc_write, retire, halted;
  logic [1:0]    trap_cause;
  ctrl_signals_t ctrl;
  int            n_checks = 0;
  int            n_pass   = 0;

  riscv_mc_ctrl_if mem_bus ();

  riscv_mc_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .branch_taken (branch_taken),
    .mem          (mem_bus.master),
    .ir_load      (ir_load),
    .pc_write     (pc_write),
    .ctrl         (ctrl),
    .retire       (retire),
    .halted       (halted),
    .trap_cause   (trap_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, then one edge into FETCH.
  task automatic do_reset();
    rst = 1'b1;
    mem_bus.imem_ready = 1'b0;
    mem_bus.dmem_ready = 1'b0;
    branch_taken = 1'b0;
    #1;
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cause", 32'(trap_cause), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("idle_ireq", 32'(mem_bus.imem_req), 32'd0);
    tick();
    check("fetch_ireq", 32'(mem_bus.imem_req), 32'd1);
  endtask

  // From FETCH: deliver w with zero wait, end in DECODE.
  task automatic fetch(input logic [31:0] w);
    instr = w;
    mem_bus.imem_ready = 1'b1;
    #1;
    check("fetch_irload", 32'(ir_load), 32'd1);
    tick();
    mem_bus.imem_ready = 1'b0;
    check("dec_ireq", 32'(mem_bus.imem_req), 32'd0);
  endtask

  task automatic run_alu(input string tag, input logic [31:0] w, input alu_op_t alu,
                         input logic [1:0] opa, input logic [1:0] opb, input logic [1:0] npc);
    fetch(w);
    check({tag, "_alu"}, 32'(ctrl.alu_op), 32'(alu));
    check({tag, "_dec_rw"}, 32'(ctrl.reg_write), 32'd0);
    tick();
    check({tag, "_ex_rw"}, 32'(ctrl.reg_write), 32'd0);
    check({tag, "_ex_ret"}, 32'(retire), 32'd0);
    tick();
    check({tag, "_wb_rw"}, 32'(ctrl.reg_write), 32'd1);
    check({tag, "_wb_ret"}, 32'(retire), 32'd1);
    check({tag, "_wb_pcw"}, 32'(pc_write), 32'd1);
    check({tag, "_opa"}, 32'(ctrl.op_a_sel), 32'(opa));
    check({tag, "_opb"}, 32'(ctrl.op_b_sel), 32'(opb));
    check({tag, "_npc"}, 32'(ctrl.next_pc_sel), 32'(npc));
    tick();
    check({tag, "_back_fetch"}, 32'(mem_bus.imem_req), 32'd1);
    check({tag, "_ret_clr"}, 32'(retire), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    instr = 32'h0;
    branch_taken = 1'b0;
    mem_bus.imem_ready = 1'b1;
    mem_bus.dmem_ready = 1'b1;
    #3;
    check("rst_ireq", 32'(mem_bus.imem_req), 32'd0);
    check("rst_dreq", 32'(mem_bus.dmem_req), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    do_reset();

    run_alu("add",   32'h002081B3, ALU_ADD, OPA_RS1,  OPB_RS2,  PC_PLUS4);
    run_alu("sub",   32'h402081B3, ALU_SUB, OPA_RS1,  OPB_RS2,  PC_PLUS4);
    run_alu("srai",  32'h4020D193, ALU_SRA, OPA_RS1,  OPB_IMM,  PC_PLUS4);
    run_alu("addi",  32'h40008193, ALU_ADD, OPA_RS1,  OPB_IMM,  PC_PLUS4);
    run_alu("lui",   32'h000011B7, ALU_ADD, OPA_ZERO, OPB_IMM,  PC_PLUS4);
    run_alu("jal",   32'h008000EF, ALU_ADD, OPA_PC,   OPB_FOUR, PC_IMM);
    run_alu("jalr",  32'h000100E7, ALU_ADD, OPA_PC,   OPB_FOUR, PC_RS1_IMM);

    // LW with dmem_ready delayed three cycles
    fetch(32'h0000A183);
    tick();
    check("lw_ex_mrd", 32'(ctrl.mem_read), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_dreq", 32'(mem_bus.dmem_req), 32'd1);
      check("lw_mem_rd", 32'(ctrl.mem_read), 32'd1);
      check("lw_mem_size", 32'(ctrl.mem_size), 32'd2);
      check("lw_mem_we", 32'(mem_bus.dmem_we), 32'd0);
      tick();
    end
    mem_bus.dmem_ready = 1'b1;
    #1;
    check("lw_mem4_dreq", 32'(mem_bus.dmem_req), 32'd1);
    check("lw_mem4_ret", 32'(retire), 32'd0);
    tick();
    mem_bus.dmem_ready = 1'b0;
    check("lw_wb_rw", 32'(ctrl.reg_write), 32'd1);
    check("lw_wb_ret", 32'(retire), 32'd1);
    check("lw_wb_dreq", 32'(mem_bus.dmem_req), 32'd0);
    tick();
    check("lw_fetch", 32'(mem_bus.imem_req), 32'd1);

    // SW zero-wait: retires from MEM
    fetch(32'h0020A023);
    tick();
    tick();
    mem_bus.dmem_ready = 1'b1;
    #1;
    check("sw_we", 32'(mem_bus.dmem_we), 32'd1);
    check("sw_mwr", 32'(ctrl.mem_write), 32'd1);
    check("sw_ret", 32'(retire), 32'd1);
    check("sw_pcw", 32'(pc_write), 32'd1);
    check("sw_rw", 32'(ctrl.reg_write), 32'd0);
    tick();
    mem_bus.dmem_ready = 1'b0;
    check("sw_fetch", 32'(mem_bus.imem_req), 32'd1);

    // BEQ taken, then not taken
    branch_taken = 1'b1;
    fetch(32'h00208463);
    tick();
    check("beq_t_pcw", 32'(pc_write), 32'd1);
    check("beq_t_ret", 32'(retire), 32'd1);
    check("beq_t_npc", 32'(ctrl.next_pc_sel), 32'(PC_IMM));
    check("beq_t_rw", 32'(ctrl.reg_write), 32'd0);
    tick();
    check("beq_t_fetch", 32'(mem_bus.imem_req), 32'd1);
    branch_taken = 1'b0;
    fetch(32'h00208463);
    tick();
    check("beq_n_npc", 32'(ctrl.next_pc_sel), 32'(PC_PLUS4));
    check("beq_n_ret", 32'(retire), 32'd1);
    tick();
    check("beq_n_fetch", 32'(mem_bus.imem_req), 32'd1);

    // All-ones instruction traps as illegal and stays trapped
    fetch(32'hFFFFFFFF);
    check("ill_dec_halt", 32'(halted), 32'd0);
    tick();
    mem_bus.imem_ready = 1'b1;
    mem_bus.dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ill_halted", 32'(halted), 32'd1);
      check("ill_cause", 32'(trap_cause), 32'(TRAP_ILLEGAL));
      check("ill_ireq", 32'(mem_bus.imem_req), 32'd0);
      tick();
    end
    do_reset();

    // R-type with funct7=0000001 is illegal here
    fetch(32'h022081B3);
    tick();
    check("mul_cause", 32'(trap_cause), 32'(TRAP_ILLEGAL));
    do_reset();

    // Fetch timeout: 16 waiting cycles trap
    for (int i = 0; i < 15; i++) tick();
    check("to16_ireq", 32'(mem_bus.imem_req), 32'd1);
    check("to16_halt", 32'(halted), 32'd0);
    tick();
    check("to_halted", 32'(halted), 32'd1);
    check("to_cause", 32'(trap_cause), 32'(TRAP_TIMEOUT));
    do_reset();

    // Ready on the 16th cycle wins over the timeout
    for (int i = 0; i < 15; i++) tick();
    instr = 32'h002081B3;
    mem_bus.imem_ready = 1'b1;
    tick();
    mem_bus.imem_ready = 1'b0;
    check("rdy16_halt", 32'(halted), 32'd0);
    check("rdy16_dec", 32'(mem_bus.imem_req), 32'd0);
    check("rdy16_alu", 32'(ctrl.alu_op), 32'(ALU_ADD));
    do_reset();

    // Reset asserted mid-MEM of SW drops outputs without a clock edge
    fetch(32'h0020A023);
    tick();
    tick();
    check("swr_dreq", 32'(mem_bus.dmem_req), 32'd1);
    check("swr_mwr", 32'(ctrl.mem_write), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("swr_dreq0", 32'(mem_bus.dmem_req), 32'd0);
    check("swr_we0", 32'(mem_bus.dmem_we), 32'd0);
    check("swr_mwr0", 32'(ctrl.mem_write), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("swr_idle", 32'(mem_bus.imem_req), 32'd0);
    tick();
    check("swr_fetch", 32'(mem_bus.imem_req), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
